// File: rtl/pe_mac_tree_acc.sv
// pe_mac_tree_acc: multiply-accumulate processing element for the conv array.
// LANES signed ifm x wgt products are reduced by a registered adder tree. Each
// tree adder is either exact or approximate (OR of the low bits), chosen per beat.
// The tree sum then feeds a saturating window accumulator that emits one result
// per first..last window.
module pe_mac_tree_acc #(
   parameter int LANES       = 4,
   parameter int DATA_W      = 8,
   parameter int ACC_W       = 32,
   parameter int APPROX_BITS = 6
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic                      in_first,
   input  logic                      in_last,
   input  logic                      approx_en,
   input  logic [LANES*DATA_W-1:0]   ifm_in,
   input  logic [LANES*DATA_W-1:0]   wgt_in,
   output logic signed [ACC_W-1:0]   p_sum,
   output logic                      out_valid,
   output logic                      out_sat
);

   localparam int LVLS   = $clog2(LANES);
   localparam int PROD_W = 2*DATA_W;
   // Every tree node is held at the final tree width. Each level's value fits
   // its own narrower width, so widening changes neither the exact sums nor the
   // approximate ones.
   localparam int SUM_W  = PROD_W + LVLS;
   localparam int ACC_X  = ACC_W + 1;
   localparam logic [SUM_W-1:0] LOW_MASK = SUM_W'((65'(1) << APPROX_BITS) - 65'(1));

   // Signed lane product, sign-extended to the tree node width.
   function automatic logic signed [SUM_W-1:0] mul_ext(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
      logic signed [PROD_W-1:0] p;
      p = PROD_W'(a) * PROD_W'(b);
      return SUM_W'(p);
   endfunction

   // Tree adder. In approximate mode the low field is a|b. The upper field is
   // added with its low bits masked to zero, so no carry can leave the low part.
   function automatic logic signed [SUM_W-1:0] tree_add(input logic signed [SUM_W-1:0] a,
                                                        input logic signed [SUM_W-1:0] b,
                                                        input logic approx);
      logic [SUM_W-1:0] hi;
      if (!approx) return a + b;
      hi = (a & ~LOW_MASK) + (b & ~LOW_MASK);
      return hi | ((a | b) & LOW_MASK);
   endfunction

   logic signed [SUM_W-1:0] prod_ext [LANES];
   // Level 0 holds the products; level k holds LANES>>k partial sums.
   logic signed [SUM_W-1:0] node_reg [LVLS+1][LANES];
   logic [LVLS:0]           valid_reg, first_reg, last_reg;
   logic [LVLS-1:0]         approx_reg;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign prod_ext[gi] = mul_ext(ifm_in[gi*DATA_W +: DATA_W], wgt_in[gi*DATA_W +: DATA_W]);
      end
   endgenerate

   // Product stage and tree levels. The beat tags shift along with the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= LVLS; k++)
            for (int j = 0; j < LANES; j++)
               node_reg[k][j] <= '0;
         valid_reg  <= '0;
         first_reg  <= '0;
         last_reg   <= '0;
         approx_reg <= '0;
      end else begin
         for (int j = 0; j < LANES; j++)
            node_reg[0][j] <= prod_ext[j];
         for (int k = 1; k <= LVLS; k++)
            for (int j = 0; j < LANES; j++)
               if (j < (LANES >> k))
                  node_reg[k][j] <= tree_add(node_reg[k-1][2*j], node_reg[k-1][2*j+1],
                                             approx_reg[k-1]);
               else
                  node_reg[k][j] <= '0;
         valid_reg     <= {valid_reg[LVLS-1:0], in_valid};
         first_reg     <= {first_reg[LVLS-1:0], in_first};
         last_reg      <= {last_reg[LVLS-1:0],  in_last};
         approx_reg[0] <= approx_en;
         for (int k = 1; k < LVLS; k++)
            approx_reg[k] <= approx_reg[k-1];
      end
   end

   logic signed [ACC_W-1:0] acc_reg, tsum_ext, acc_base, acc_next;
   logic signed [ACC_X-1:0] acc_wide;
   logic                    sat_reg, ovf, sat_next;

   // Next accumulator value. A first beat restarts the window from zero.
   // The sum is one bit wider so that overflow is seen before the clamp.
   always_comb begin
      tsum_ext = ACC_W'(node_reg[LVLS][0]);
      acc_base = first_reg[LVLS] ? '0 : acc_reg;
      acc_wide = ACC_X'(acc_base) + ACC_X'(tsum_ext);
      ovf      = acc_wide[ACC_W] != acc_wide[ACC_W-1];
      if (!ovf)
         acc_next = acc_wide[ACC_W-1:0];
      else if (acc_wide[ACC_W])
         acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      else
         acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      sat_next = ovf | (~first_reg[LVLS] & sat_reg);
   end

   // Accumulate valid beats and publish the window result on a last beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg   <= '0;
         sat_reg   <= 1'b0;
         p_sum     <= '0;
         out_sat   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= valid_reg[LVLS] & last_reg[LVLS];
         if (valid_reg[LVLS]) begin
            acc_reg <= acc_next;
            sat_reg <= sat_next;
            if (last_reg[LVLS]) begin
               p_sum   <= acc_next;
               out_sat <= sat_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_pe_mac_tree_acc.sv
// Testbench for pe_mac_tree_acc (LANES=4, DATA_W=8, APPROX_BITS=6).
// The bench drives two instances from the same stimulus, one with ACC_W=32 and
// one with ACC_W=18. When it drives a last beat it pushes the expected result
// into a per-instance queue. A monitor pops that queue when out_valid appears.
module tb_pe_mac_tree_acc;

   localparam int AB = 6;
   typedef int vec_t [4];
   typedef struct { longint v; bit s; string tag; } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, approx_en = 1'b0;
   logic [31:0] ifm_in = '0, wgt_in = '0;
   logic signed [31:0] p_sum32;
   logic signed [17:0] p_sum18;
   logic out_valid32, out_sat32, out_valid18, out_sat18;

   int tests_run = 0, tests_failed = 0;
   int cyc = 0, beat_cyc = 0, last_out_cyc = -100, prev_out_cyc = -100;
   exp_t q32[$], q18[$];
   longint m_acc32 = 0, m_acc18 = 0;
   bit m_sat32 = 0, m_sat18 = 0;
   vec_t va, vw;

   pe_mac_tree_acc #(.LANES(4), .DATA_W(8), .ACC_W(32), .APPROX_BITS(AB)) dut32 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .approx_en(approx_en), .ifm_in(ifm_in), .wgt_in(wgt_in),
      .p_sum(p_sum32), .out_valid(out_valid32), .out_sat(out_sat32));

   pe_mac_tree_acc #(.LANES(4), .DATA_W(8), .ACC_W(18), .APPROX_BITS(AB)) dut18 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
      .approx_en(approx_en), .ifm_in(ifm_in), .wgt_in(wgt_in),
      .p_sum(p_sum18), .out_valid(out_valid18), .out_sat(out_sat18));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint got, input longint exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference adder: the upper field is added exactly and the low field is OR-ed.
   function automatic longint add_m(input longint x, input longint y, input bit ap);
      longint m;
      if (!ap) return x + y;
      m = (longint'(1) <<< AB) - 1;
      return (((x >>> AB) + (y >>> AB)) <<< AB) + ((x | y) & m);
   endfunction

   function automatic longint tree_model(input vec_t a, input vec_t w, input bit ap);
      longint p[4];
      for (int i = 0; i < 4; i++) p[i] = longint'(a[i]) * longint'(w[i]);
      return add_m(add_m(p[0], p[1], ap), add_m(p[2], p[3], ap), ap);
   endfunction

   function automatic longint sat_acc(input longint base, input longint t, input int w,
                                      output bit ovf);
      longint mx, mn, s;
      mx = (longint'(1) <<< (w - 1)) - 1;
      mn = -mx - 1;
      s = base + t;
      ovf = 0;
      if (s > mx) begin s = mx; ovf = 1; end
      else if (s < mn) begin s = mn; ovf = 1; end
      return s;
   endfunction

   task automatic push_exp(input string tag, input longint v32, input bit s32,
                           input longint v18, input bit s18);
      q32.push_back('{v: v32, s: s32, tag: tag});
      q18.push_back('{v: v18, s: s18, tag: tag});
   endtask

   // Drive one beat and advance the reference accumulators. When use_model is
   // set, a last beat also pushes the model's result.
   task automatic beat(input bit f, input bit l, input bit ap, input bit use_model);
      longint t;
      bit o;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         ifm_in[i*8 +: 8] = 8'(va[i]);
         wgt_in[i*8 +: 8] = 8'(vw[i]);
      end
      in_valid = 1'b1; in_first = f; in_last = l; approx_en = ap;
      beat_cyc = cyc;
      t = tree_model(va, vw, ap);
      m_acc32 = sat_acc(f ? 0 : m_acc32, t, 32, o);
      m_sat32 = o | (!f && m_sat32);
      m_acc18 = sat_acc(f ? 0 : m_acc18, t, 18, o);
      m_sat18 = o | (!f && m_sat18);
      if (l && use_model) push_exp("rnd", m_acc32, m_sat32, m_acc18, m_sat18);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 30 && (q32.size() != 0 || q18.size() != 0); i++) @(negedge clk);
      chk("drain32", q32.size(), 0);
      chk("drain18", q18.size(), 0);
   endtask

   task automatic fill(input int a, input int w);
      for (int i = 0; i < 4; i++) begin va[i] = a; vw[i] = w; end
   endtask

   // Scoreboard: every out_valid pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (out_valid32) begin
         prev_out_cyc = last_out_cyc;
         last_out_cyc = cyc;
         if (q32.size() == 0) chk("spurious_valid32", longint'(out_valid32), 0);
         else begin
            e = q32.pop_front();
            $display("[TB] out32 %s p_sum=%0d sat=%0d exp=%0d/%0d", e.tag, p_sum32, out_sat32, e.v, e.s);
            chk({e.tag, "_psum32"}, longint'(p_sum32), e.v);
            chk({e.tag, "_sat32"}, longint'(out_sat32), longint'(e.s));
         end
      end
      if (out_valid18) begin
         if (q18.size() == 0) chk("spurious_valid18", longint'(out_valid18), 0);
         else begin
            e = q18.pop_front();
            $display("[TB] out18 %s p_sum=%0d sat=%0d exp=%0d/%0d", e.tag, p_sum18, out_sat18, e.v, e.s);
            chk({e.tag, "_psum18"}, longint'(p_sum18), e.v);
            chk({e.tag, "_sat18"}, longint'(out_sat18), longint'(e.s));
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_psum32", longint'(p_sum32), 0);
      chk("rst_valid32", longint'(out_valid32), 0);
      chk("rst_sat18", longint'(out_sat18), 0);
      rst_n = 1'b1;

      // exact single beat, latency 4
      va = '{1, 2, 3, 4}; vw = '{5, 6, 7, 8};
      push_exp("exact70", 70, 0, 70, 0);
      beat(1, 1, 0, 0);
      drain();
      chk("latency", last_out_cyc - beat_cyc, 4);

      // approximate vs exact, back-to-back single-beat windows
      va = '{3, 1, 0, 0}; vw = '{1, 1, 0, 0};
      push_exp("approx3", 3, 0, 3, 0);
      beat(1, 1, 1, 0);
      push_exp("exact4", 4, 0, 4, 0);
      beat(1, 1, 0, 0);
      drain();
      chk("b2b_gap", last_out_cyc - prev_out_cyc, 1);

      // three-beat window of 127*127 (saturates in the 18-bit instance)
      fill(127, 127);
      beat(1, 0, 0, 0);
      beat(0, 0, 0, 0);
      push_exp("multi3", 193548, 0, 131071, 1);
      beat(0, 1, 0, 0);
      drain();

      // signs
      fill(-128, 127);
      push_exp("neg", -65024, 0, -65024, 0);
      beat(1, 1, 0, 0);
      fill(-128, -128);
      push_exp("pos", 65536, 0, 65536, 0);
      beat(1, 1, 0, 0);
      drain();

      // saturation then sticky flag cleared by the next window
      fill(-128, -128);
      beat(1, 0, 0, 0);
      beat(0, 0, 0, 0);
      beat(0, 0, 0, 0);
      push_exp("sat4", 262144, 0, 131071, 1);
      beat(0, 1, 0, 0);
      va = '{1, 2, 3, 4}; vw = '{5, 6, 7, 8};
      push_exp("after_sat", 70, 0, 70, 0);
      beat(1, 1, 0, 0);
      drain();

      // random stream: bubbles, restarts, orphan last beats, mixed approx
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) idle();
         else begin
            for (int i = 0; i < 4; i++) begin
               va[i] = int'($urandom_range(0, 255)) - 128;
               vw[i] = int'($urandom_range(0, 255)) - 128;
            end
            beat($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)), 1);
         end
      end
      drain();

      // reset in the middle of a window: nothing emitted, outputs cleared
      fill(100, 100);
      beat(1, 0, 0, 0);
      beat(0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      @(negedge clk);
      chk("midrst_psum32", longint'(p_sum32), 0);
      chk("midrst_psum18", longint'(p_sum18), 0);
      chk("midrst_valid32", longint'(out_valid32), 0);
      chk("midrst_sat32", longint'(out_sat32), 0);
      rst_n = 1'b1;
      m_acc32 = 0; m_sat32 = 0; m_acc18 = 0; m_sat18 = 0;
      repeat (8) @(negedge clk);
      chk("post_rst_psum32", longint'(p_sum32), 0);

      // first=0 after reset accumulates onto zero
      va = '{1, 2, 3, 4}; vw = '{5, 6, 7, 8};
      push_exp("nofirst", 70, 0, 70, 0);
      beat(0, 1, 0, 0);
      drain();

      chk("queues_empty", q32.size() + q18.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
